// File: rtl/framebuffer_sink_if.sv
// Pixel-plot and raster-readback bundle between drawing engines / checkers and framebuffer_sink.
// Readback handshake: a pixel transfers on any rising edge where rd_valid && rd_ready; while rd_valid is
// high and rd_ready is low the presented rd_x/rd_y/rd_colour hold stable, and rd_valid never drops without a transfer.
interface framebuffer_sink_if;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic [15:0] plot_count;
    logic        oob_err;
    logic        scan_start;
    logic        scan_busy;
    logic        scan_done;
    logic [7:0]  rd_x;
    logic [6:0]  rd_y;
    logic [2:0]  rd_colour;
    logic        rd_valid;
    logic        rd_ready;

    modport master (
        output vga_x, vga_y, vga_colour, vga_plot, scan_start, rd_ready,
        input  plot_count, oob_err, scan_busy, scan_done, rd_x, rd_y, rd_colour, rd_valid
    );

    modport slave (
        input  vga_x, vga_y, vga_colour, vga_plot, scan_start, rd_ready,
        output plot_count, oob_err, scan_busy, scan_done, rd_x, rd_y, rd_colour, rd_valid
    );
endinterface

// File: rtl/framebuffer_sink.sv
// Framebuffer sink: stores plotted pixels, counts accepted plots, flags out-of-range plots,
// and streams the image back in raster order through a valid/ready port.
module framebuffer_sink #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120
) (
    input  logic               clk,
    input  logic               rst_n,
    framebuffer_sink_if.slave  fb,
    output logic [1:0]         scan_state
);
    localparam int DEPTH = WIDTH * HEIGHT;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0] XMAX = 8'(WIDTH - 1);
    localparam logic [6:0] YMAX = 7'(HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, FETCH, PRESENT, DONE} state_t;

    state_t      state, state_n;
    logic [2:0]  mem [DEPTH];
    logic [2:0]  rd_data;
    logic [7:0]  sx, rd_x_q;
    logic [6:0]  sy, rd_y_q;
    logic [15:0] count_q;
    logic        oob_q;
    logic        in_range, wr_en, handshake, last_px;
    logic [AW-1:0] wr_addr, rd_addr;

    // Widened compares keep the range check correct even when WIDTH/HEIGHT hit the port limits.
    assign in_range  = ({1'b0, fb.vga_x} < 9'(WIDTH)) && ({1'b0, fb.vga_y} < 8'(HEIGHT));
    assign wr_en     = fb.vga_plot && in_range;
    assign wr_addr   = AW'(fb.vga_y) * AW'(WIDTH) + AW'(fb.vga_x);
    assign rd_addr   = AW'(sy) * AW'(WIDTH) + AW'(sx);
    assign handshake = (state == PRESENT) && fb.rd_ready;
    assign last_px   = (sx == XMAX) && (sy == YMAX);

    // Memory contents survive reset; only the read register and scan position are cleared.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en)
            mem[wr_addr] <= fb.vga_colour;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data <= 3'd0;
            rd_x_q  <= 8'd0;
            rd_y_q  <= 7'd0;
        end else if (state == FETCH) begin
            rd_data <= mem[rd_addr];
            rd_x_q  <= sx;
            rd_y_q  <= sy;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= 16'd0;
            oob_q   <= 1'b0;
        end else if (fb.vga_plot) begin
            if (in_range) begin
                if (count_q != 16'hFFFF)
                    count_q <= count_q + 16'd1;
            end else begin
                oob_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sx <= 8'd0;
            sy <= 7'd0;
        end else if ((state == IDLE) && fb.scan_start) begin
            sx <= 8'd0;
            sy <= 7'd0;
        end else if (handshake && !last_px) begin
            if (sx == XMAX) begin
                sx <= 8'd0;
                sy <= sy + 7'd1;
            end else begin
                sx <= sx + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (fb.scan_start) state_n = FETCH;
            FETCH:   state_n = PRESENT;
            PRESENT: if (handshake) state_n = last_px ? DONE : FETCH;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign scan_state    = state;
    assign fb.plot_count = count_q;
    assign fb.oob_err    = oob_q;
    assign fb.scan_busy  = (state != IDLE);
    assign fb.scan_done  = (state == DONE);
    assign fb.rd_valid   = (state == PRESENT);
    assign fb.rd_x       = rd_x_q;
    assign fb.rd_y       = rd_y_q;
    assign fb.rd_colour  = rd_data;
endmodule

// File: tb/tb_framebuffer_sink.sv
// Directed-plus-random bench for framebuffer_sink on a 4x3 screen, checked against a pixel-array model.
module tb_framebuffer_sink;
    localparam int W = 4;
    localparam int H = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] scan_state;
    int         checks = 0;
    int         errors = 0;

    int         model_fb [W*H];
    int         model_cnt;
    bit         model_oob;
    logic [14:0] exp_q [$];

    int         sp_idx [2];
    int         sp_x [2];
    int         sp_y [2];
    int         sp_c [2];

    framebuffer_sink_if bus ();

    framebuffer_sink #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fb         (bus),
        .scan_state (scan_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void model_plot(input int x, input int y, input int c);
        if (x < W && y < H) begin
            model_fb[y*W + x] = c;
            model_cnt = (model_cnt == 65535) ? 65535 : model_cnt + 1;
        end else begin
            model_oob = 1'b1;
        end
    endfunction

    task automatic do_plot(input int x, input int y, input int c);
        bus.vga_x      = 8'(x);
        bus.vga_y      = 7'(y);
        bus.vga_colour = 3'(c);
        bus.vga_plot   = 1'b1;
        tick();
        bus.vga_plot   = 1'b0;
        model_plot(x, y, c);
    endtask

    task automatic check_counters(input string tag);
        chk({tag, "_count"}, bus.plot_count, model_cnt);
        chk({tag, "_oob"}, bus.oob_err, model_oob);
    endtask

    // Expected colour is the model contents at the moment a pixel is first presented.
    task automatic run_scan(input int ready_pct, input int hold_idx);
        logic [7:0] ex;
        logic [6:0] ey;
        logic [2:0] ec;
        int stalls;
        int pk;
        exp_q.delete();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                exp_q.push_back({8'(x), 7'(y)});
        bus.scan_start = 1'b1;
        tick();
        bus.scan_start = 1'b0;
        chk("start_busy", bus.scan_busy, 1);
        chk("start_valid", bus.rd_valid, 0);
        tick();
        for (int idx = 0; idx < W*H; idx++) begin
            {ex, ey} = exp_q.pop_front();
            ec = 3'(model_fb[ey*W + ex]);
            chk("rd_valid", bus.rd_valid, 1);
            chk("rd_x", bus.rd_x, ex);
            chk("rd_y", bus.rd_y, ey);
            chk("rd_colour", bus.rd_colour, ec);
            chk("present_busy", bus.scan_busy, 1);
            if (idx == hold_idx)
                stalls = 5;
            else if (ready_pct < 100 && $urandom_range(0, 99) >= ready_pct)
                stalls = $urandom_range(1, 3);
            else
                stalls = 0;
            for (int s = 0; s < stalls; s++) begin
                bus.rd_ready   = 1'b0;
                bus.scan_start = 1'b1;
                tick();
                chk("hold_valid", bus.rd_valid, 1);
                chk("hold_x", bus.rd_x, ex);
                chk("hold_y", bus.rd_y, ey);
                chk("hold_colour", bus.rd_colour, ec);
            end
            bus.rd_ready   = 1'b1;
            bus.scan_start = 1'($urandom_range(0, 1));
            pk = -1;
            for (int k = 0; k < 2; k++) begin
                if (sp_idx[k] == idx) begin
                    bus.vga_x      = 8'(sp_x[k]);
                    bus.vga_y      = 7'(sp_y[k]);
                    bus.vga_colour = 3'(sp_c[k]);
                    bus.vga_plot   = 1'b1;
                    pk = k;
                end
            end
            tick();
            bus.rd_ready = 1'b0;
            if (pk >= 0) begin
                bus.vga_plot = 1'b0;
                model_plot(sp_x[pk], sp_y[pk], sp_c[pk]);
            end
            if (idx < W*H - 1) begin
                chk("fetch_valid", bus.rd_valid, 0);
                chk("fetch_busy", bus.scan_busy, 1);
                bus.scan_start = 1'($urandom_range(0, 1));
                tick();
                bus.scan_start = 1'b0;
            end else begin
                chk("done_pulse", bus.scan_done, 1);
                chk("done_busy", bus.scan_busy, 1);
                chk("done_valid", bus.rd_valid, 0);
                bus.scan_start = 1'b1;
                tick();
                bus.scan_start = 1'b0;
                chk("idle_busy", bus.scan_busy, 0);
                chk("done_once", bus.scan_done, 0);
                tick();
                chk("no_restart", bus.scan_busy, 0);
            end
        end
        sp_idx[0] = -1;
        sp_idx[1] = -1;
    endtask

    initial begin
        sp_idx[0] = -1;
        sp_idx[1] = -1;
        model_cnt = 0;
        model_oob = 1'b0;
        for (int i = 0; i < W*H; i++) model_fb[i] = 0;
        rst_n          = 1'b0;
        bus.vga_x      = 8'd0;
        bus.vga_y      = 7'd0;
        bus.vga_colour = 3'd0;
        bus.vga_plot   = 1'b0;
        bus.scan_start = 1'b0;
        bus.rd_ready   = 1'b0;
        tick();
        tick();
        chk("rst_count", bus.plot_count, 0);
        chk("rst_oob", bus.oob_err, 0);
        chk("rst_busy", bus.scan_busy, 0);
        chk("rst_done", bus.scan_done, 0);
        chk("rst_valid", bus.rd_valid, 0);
        chk("rst_x", bus.rd_x, 0);
        chk("rst_y", bus.rd_y, 0);
        chk("rst_colour", bus.rd_colour, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_busy", bus.scan_busy, 0);
        end

        // Fill every pixel with (x+y)%8, then a full-rate scan.
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                do_plot(x, y, (x + y) % 8);
        check_counters("fill");
        run_scan(100, -1);

        // Backpressure while pixel (2,1) is presented.
        run_scan(100, 1*W + 2);

        // Out-of-range plots leave memory and count untouched.
        do_plot(4, 0, 7);
        do_plot(0, 3, 7);
        check_counters("oob");
        run_scan(60, -1);
        do_plot($urandom_range(0, W-1), $urandom_range(0, H-1), $urandom_range(0, 7));
        check_counters("oob_sticky");

        // Random plots, some out of range, then a scan with random stalls.
        for (int i = 0; i < 20; i++)
            do_plot($urandom_range(0, W+1), $urandom_range(0, H+1), $urandom_range(0, 7));
        check_counters("rand");
        run_scan(50, -1);

        // Writes during a scan: (3,2) is fetched later, (0,0) was already consumed.
        do_plot(0, 0, 1);
        do_plot(3, 2, 2);
        sp_idx[0] = 0; sp_x[0] = 3; sp_y[0] = 2; sp_c[0] = 5;
        sp_idx[1] = 1; sp_x[1] = 0; sp_y[1] = 0; sp_c[1] = 6;
        run_scan(100, -1);
        check_counters("wscan");
        run_scan(100, -1);

        // Reset in the middle of a scan.
        bus.scan_start = 1'b1;
        tick();
        bus.scan_start = 1'b0;
        tick();
        bus.rd_ready = 1'b1;
        tick();
        tick();
        bus.rd_ready = 1'b0;
        chk("pre_rst_valid", bus.rd_valid, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_cnt = 0;
        model_oob = 1'b0;
        chk("mrst_valid", bus.rd_valid, 0);
        chk("mrst_busy", bus.scan_busy, 0);
        chk("mrst_x", bus.rd_x, 0);
        chk("mrst_y", bus.rd_y, 0);
        chk("mrst_colour", bus.rd_colour, 0);
        check_counters("mrst");
        tick();
        chk("mrst_idle", bus.scan_busy, 0);
        run_scan(70, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
